// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the ROM and loads IF/ID; IF_ALIGN_CHECK_EN adds id_adel.
// Latency: one edge from inst_addr to id_inst (ROM is combinational).
// Backpressure: stall_pc freezes the PC (branches are parked in pending), stall_id freezes IF/ID.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_pc,
   input  logic        stall_id,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        inst_ce,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_data,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
`ifdef IF_ALIGN_CHECK_EN
   output logic        id_adel,
`endif
   output logic        id_valid
);

   logic [31:0] pc;
   logic [31:0] pend_pc;
   logic        pend_vld;
   logic        ce;
   logic        hold_pc;

   // stall_id without stall_pc is illegal upstream; treat it as a PC stall anyway
   assign hold_pc   = stall_pc | stall_id;
   assign inst_ce   = ce;
   assign inst_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce       <= 1'b0;
         pc       <= RESET_PC;
         pend_pc  <= 32'h0;
         pend_vld <= 1'b0;
      end else begin
         ce <= 1'b1;
         if (ce) begin
            if (flush) begin
               pc       <= new_pc;
               pend_vld <= 1'b0;
            end else if (hold_pc) begin
               if (branch_flag) begin
                  pend_pc  <= branch_target;
                  pend_vld <= 1'b1;
               end
            end else if (branch_flag) begin
               // a fresh branch supersedes any parked target
               pc       <= branch_target;
               pend_vld <= 1'b0;
            end else if (pend_vld) begin
               pc       <= pend_pc;
               pend_vld <= 1'b0;
            end else begin
               pc <= pc + 32'd4;
            end
         end
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   logic misalign;
   assign misalign = |pc[1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc    <= 32'h0;
         id_inst  <= NOP_INST;
         id_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
         id_adel  <= 1'b0;
`endif
      end else if (flush) begin
         id_pc    <= 32'h0;
         id_inst  <= NOP_INST;
         id_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
         id_adel  <= 1'b0;
`endif
      end else if (stall_id) begin
         id_pc    <= id_pc;
      end else if (stall_pc || !ce) begin
         id_inst  <= NOP_INST;
         id_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
         id_adel  <= 1'b0;
`endif
      end else begin
         id_pc    <= pc;
         id_valid <= 1'b1;
`ifdef IF_ALIGN_CHECK_EN
         // misaligned fetch still occupies the slot so ID can raise the exception
         id_inst  <= misalign ? NOP_INST : inst_data;
         id_adel  <= misalign;
`else
         id_inst  <= inst_data;
`endif
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage with a combinational ROM model and an expectation queue.
module tb_if_stage;

`ifdef IF_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_pc, stall_id, flush, branch_flag;
   logic [31:0] new_pc, branch_target;
   logic        inst_ce;
   logic [31:0] inst_addr, inst_data;
   logic [31:0] id_pc, id_inst;
   logic        id_valid;
   logic        id_adel_obs;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a[31:2])
         30'd0:   rom = 32'h0000_0011;
         30'd1:   rom = 32'h0000_0022;
         30'd2:   rom = 32'h0000_0033;
         default: rom = {a[31:2], 2'b00} ^ 32'hC0DE_0000;
      endcase
   endfunction

   assign inst_data = rom(inst_addr);

   if_stage dut (
      .clk(clk), .rst(rst),
      .stall_pc(stall_pc), .stall_id(stall_id),
      .flush(flush), .new_pc(new_pc),
      .branch_flag(branch_flag), .branch_target(branch_target),
      .inst_ce(inst_ce), .inst_addr(inst_addr), .inst_data(inst_data),
      .id_pc(id_pc), .id_inst(id_inst),
`ifdef IF_ALIGN_CHECK_EN
      .id_adel(id_adel_obs),
`endif
      .id_valid(id_valid)
   );

`ifndef IF_ALIGN_CHECK_EN
   assign id_adel_obs = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc_nxt;
      logic [31:0] id_pc;
      logic [31:0] id_inst;
      logic        vld;
      logic        adel;
   } exp_t;

   exp_t sb[$];

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] exp_pc;
   logic [31:0] exp_id_pc, exp_id_inst;
   logic        exp_vld, exp_adel;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ce"},    {31'h0, inst_ce}, 32'h0);
      check({tag, "_addr"},  inst_addr, 32'h0);
      check({tag, "_idpc"},  id_pc, 32'h0);
      check({tag, "_idins"}, id_inst, 32'h0);
      check({tag, "_idvld"}, {31'h0, id_valid}, 32'h0);
      if (ALIGN) check({tag, "_adel"}, {31'h0, id_adel_obs}, 32'h0);
   endtask

   // first edge after reset release: enable rises, PC still at reset value, bubble in ID
   task automatic start_up(input string tag);
      rst = 1'b0;
      @(posedge clk); #1;
      check({tag, "_ce1"},   {31'h0, inst_ce}, 32'h1);
      check({tag, "_addr0"}, inst_addr, 32'h0);
      check({tag, "_vld0"},  {31'h0, id_valid}, 32'h0);
      exp_pc = 32'h0; exp_id_pc = 32'h0; exp_id_inst = 32'h0;
      exp_vld = 1'b0; exp_adel = 1'b0;
   endtask

   task automatic step(input string tag,
                       input logic sp, input logic sid,
                       input logic fl, input logic [31:0] npc,
                       input logic bf, input logic [31:0] bt,
                       input logic [31:0] pc_nxt);
      exp_t e;
      e.pc_nxt = pc_nxt;
      if (fl) begin
         e.id_pc = 32'h0; e.id_inst = 32'h0; e.vld = 1'b0; e.adel = 1'b0;
      end else if (sid) begin
         e.id_pc = exp_id_pc; e.id_inst = exp_id_inst; e.vld = exp_vld; e.adel = exp_adel;
      end else if (sp) begin
         e.id_pc = exp_id_pc; e.id_inst = 32'h0; e.vld = 1'b0; e.adel = 1'b0;
      end else begin
         e.id_pc = exp_pc; e.vld = 1'b1;
         if (ALIGN && exp_pc[1:0] != 2'b00) begin
            e.id_inst = 32'h0; e.adel = 1'b1;
         end else begin
            e.id_inst = rom(exp_pc); e.adel = 1'b0;
         end
      end
      sb.push_back(e);
      stall_pc = sp; stall_id = sid; flush = fl; new_pc = npc;
      branch_flag = bf; branch_target = bt;
      @(posedge clk); #1;
      stall_pc = 1'b0; stall_id = 1'b0; flush = 1'b0; branch_flag = 1'b0;
      e = sb.pop_front();
      check({tag, "_ce"},    {31'h0, inst_ce}, 32'h1);
      check({tag, "_addr"},  inst_addr, e.pc_nxt);
      check({tag, "_idpc"},  id_pc, e.id_pc);
      check({tag, "_idins"}, id_inst, e.id_inst);
      check({tag, "_idvld"}, {31'h0, id_valid}, {31'h0, e.vld});
      if (ALIGN) check({tag, "_adel"}, {31'h0, id_adel_obs}, {31'h0, e.adel});
      exp_pc = e.pc_nxt; exp_id_pc = e.id_pc; exp_id_inst = e.id_inst;
      exp_vld = e.vld; exp_adel = e.adel;
   endtask

   task automatic nop_step(input string tag, input logic [31:0] pc_nxt);
      step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, pc_nxt);
   endtask

   initial begin
      rst = 1'b1;
      stall_pc = 1'b0; stall_id = 1'b0; flush = 1'b0; branch_flag = 1'b0;
      new_pc = 32'h0; branch_target = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst");
      start_up("start");

      // sequential fetch of 0x11, 0x22, 0x33 then on to 0x20
      for (int a = 4; a <= 32'h20; a += 4) nop_step("seq", a);

      // branch at 0x20: delay slot 0x20 captured, PC to 0x100
      step("br", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'h100);
      nop_step("br_tgt", 32'h104);

      // three-cycle stall with branch parked in the second cycle
      step("stl1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   32'h104);
      step("stl2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 32'h104);
      step("stl3", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   32'h104);
      nop_step("stl_rel", 32'h200);
      nop_step("stl_tgt", 32'h204);

      // ID stall holds IF/ID; stall_id alone still holds PC
      step("sid1", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h204);
      step("sid2", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h204);
      nop_step("sid_rel", 32'h208);

      // second branch during stall overwrites the parked target
      step("ovr1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 32'h208);
      step("ovr2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h340, 32'h208);
      nop_step("ovr_rel", 32'h340);
      nop_step("ovr_nxt", 32'h344);

      // flush beats stall and branch, and discards the parked target
      step("fl_pre", 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h3C0, 32'h344);
      step("fl",     1'b1, 1'b0, 1'b1, 32'h380, 1'b1, 32'h3E0, 32'h380);
      nop_step("fl_n1", 32'h384);
      nop_step("fl_n2", 32'h388);

      // PC wrap-around
      step("wrap_fl", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC);
      nop_step("wrap", 32'h0);
      nop_step("wrap_n", 32'h4);

      // misaligned branch target (ROM ignores low bits when unchecked)
      step("mis_br", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 32'h102);
      nop_step("mis1", 32'h106);
      nop_step("mis2", 32'h10A);
      step("mis_fl", 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 32'h40);
      nop_step("mis_ok", 32'h44);

      // park a branch, then assert reset between edges
      step("pre_rst", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 32'h44);
      #2 rst = 1'b1;
      #1;
      check_reset_vals("arst");
      @(posedge clk); #1;
      start_up("restart");
      nop_step("rs1", 32'h4);
      nop_step("rs2", 32'h8);
      nop_step("rs3", 32'hC);

      if (sb.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
